// File: rtl/dpram_sweep_pkg.sv
// rtl/dpram_sweep_pkg.sv - shared constants and types for the sweeping dual-port RAM
//
// Purpose: read-mode selectors, sequencer state encoding, collision counter
// width and an index-width helper shared by dpram_sweep and dpram_sweep_seq.
// Ports: none (package).

package dpram_sweep_pkg;

    localparam int RM_WRITE_FIRST = 0;
    localparam int RM_READ_FIRST  = 1;

    localparam int COLL_CNT_W = 16;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A single-word array (LEVEL=0) still needs a one-bit index signal.
    function automatic int idx_width(input int level);
        return (level > 0) ? level : 1;
    endfunction

endpackage

// File: rtl/dpram_sweep_seq.sv
// rtl/dpram_sweep_seq.sv - SWEEP/RUN sequencer that walks the clear pointer
//
// Purpose: after rst or init, visits every word once (one per cycle) so the
// top level can overwrite it with the clear value, then enters RUN.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   init            one-cycle clear request, restarts the sweep from word 0
//   busy            registered, high while sweeping
//   sweep_we        sweep write request for the current pointer
//   sweep_addr      word index being cleared

module dpram_sweep_seq
    import dpram_sweep_pkg::*;
#(
    parameter int LEVEL = 1,
    parameter int IW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    output logic          busy,
    output logic          sweep_we,
    output logic [IW-1:0] sweep_addr
);

    localparam logic [IW-1:0] LAST = IW'((1 << LEVEL) - 1);

    state_t        state;
    logic [IW-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            state <= ST_SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_SWEEP: begin
                    if (ptr == LAST) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + IW'(1);
                    end
                end
                ST_RUN: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= ST_SWEEP;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign sweep_we   = (state == ST_SWEEP);
    assign sweep_addr = ptr;

endmodule

// File: rtl/dpram_sweep.sv
// rtl/dpram_sweep.sv - true dual-port RAM with registered reads and a clear sweep
//
// Purpose: per-level heap store. 2^LEVEL words, registered read on both
// ports, write-first or read-first read-during-write, port A wins a
// same-address double write and raises a one-cycle coll pulse. A clear
// sweep fills the array with INIT_VALUE after rst or init.
// Optional build macro: DPRAM_SWEEP_COLL_CNT_EN builds the 16-bit
// saturating collision counter; otherwise coll_cnt is tied to zero.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   init                           one-cycle clear request
//   busy                           high while the clear sweep runs
//   data_a, we_a, addr_a, q_a      port A write data/enable, address, read data
//   data_b, we_b, addr_b, q_b      port B, same as port A
//   coll                           one-cycle pulse after a same-address double write
//   coll_cnt                       saturating collision count

module dpram_sweep
    import dpram_sweep_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    LEVEL      = 1,
    parameter int                    READ_MODE  = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  coll,
    output logic [COLL_CNT_W-1:0] coll_cnt
);

    localparam int                    IW        = idx_width(LEVEL);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'((1 << LEVEL) - 1);

    logic [DATA_WIDTH-1:0] mem [0:(1 << IW) - 1];

    logic          sweep_we;
    logic [IW-1:0] sweep_addr;

    dpram_sweep_seq #(
        .LEVEL (LEVEL),
        .IW    (IW)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Upper address bits are masked off; with LEVEL=0 every access is word 0.
    logic [IW-1:0] ea_a;
    logic [IW-1:0] ea_b;
    assign ea_a = IW'(addr_a & ADDR_MASK);
    assign ea_b = IW'(addr_b & ADDR_MASK);

    // rst/init take the edge for the sequencer, so nothing is written then.
    logic accept;
    logic sweep_wr;
    logic wr_a;
    logic wr_b;
    logic same;
    logic hit_coll;
    logic wr_b_eff;

    assign accept   = !rst && !init && !busy;
    assign sweep_wr = sweep_we && !rst && !init;
    assign wr_a     = we_a && accept;
    assign wr_b     = we_b && accept;
    assign same     = (ea_a == ea_b);
    assign hit_coll = wr_a && wr_b && same;
    assign wr_b_eff = wr_b && !(wr_a && same);

    // The sweep borrows port A; user writes never coincide with it.
    logic                  pa_we;
    logic [IW-1:0]         pa_addr;
    logic [DATA_WIDTH-1:0] pa_data;

    assign pa_we   = sweep_wr || wr_a;
    assign pa_addr = sweep_we ? sweep_addr : ea_a;
    assign pa_data = sweep_we ? INIT_VALUE : data_a;

    always_ff @(posedge clk) begin
        if (pa_we) begin
            mem[pa_addr] <= pa_data;
        end
        if (wr_b_eff) begin
            mem[ea_b] <= data_b;
        end
    end

    // Write-first read values: the value the word will hold after this edge,
    // with port A's data taking precedence on a collision.
    logic [DATA_WIDTH-1:0] wf_a;
    logic [DATA_WIDTH-1:0] wf_b;

    assign wf_a = wr_a          ? data_a :
                  (wr_b && same) ? data_b : mem[ea_a];
    assign wf_b = (wr_a && same) ? data_a :
                  wr_b           ? data_b : mem[ea_b];

    always_ff @(posedge clk) begin
        if (rst || init || busy) begin
            q_a <= '0;
            q_b <= '0;
        end else if (READ_MODE == RM_READ_FIRST) begin
            q_a <= mem[ea_a];
            q_b <= mem[ea_b];
        end else begin
            q_a <= wf_a;
            q_b <= wf_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll <= 1'b0;
        end else begin
            coll <= hit_coll;
        end
    end

`ifdef DPRAM_SWEEP_COLL_CNT_EN
    logic [COLL_CNT_W-1:0] cnt_q;

    // Cleared only by rst so the count survives clear sweeps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (hit_coll && (cnt_q != '1)) begin
            cnt_q <= cnt_q + COLL_CNT_W'(1);
        end
    end

    assign coll_cnt = cnt_q;
`else
    assign coll_cnt = '0;
`endif

endmodule

// File: tb/tb_dpram_sweep.sv
// tb/tb_dpram_sweep.sv - self-checking bench for dpram_sweep across four configurations

module tb_dpram_sweep;

    localparam int NI = 4;
    localparam int LV  [NI] = '{3, 3, 2, 0};
    localparam int RMV [NI] = '{0, 1, 0, 0};
    localparam logic [31:0] IVV [NI] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0000_0000, 32'h5A5A0F0F};

    logic        clk = 1'b0;
    logic        rst, init;
    logic [31:0] data_a, data_b;
    logic        we_a, we_b;
    logic [4:0]  addr_a, addr_b;

    logic        busy [NI];
    logic [31:0] qa   [NI];
    logic [31:0] qb   [NI];
    logic        coll [NI];
    logic [15:0] cnt  [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dpram_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LEVEL(3), .READ_MODE(0), .INIT_VALUE(32'hA5A5A5A5)) u0 (
        .clk(clk), .rst(rst), .init(init), .busy(busy[0]),
        .data_a(data_a), .we_a(we_a), .addr_a(addr_a), .q_a(qa[0]),
        .data_b(data_b), .we_b(we_b), .addr_b(addr_b), .q_b(qb[0]),
        .coll(coll[0]), .coll_cnt(cnt[0]));
    dpram_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LEVEL(3), .READ_MODE(1), .INIT_VALUE(32'hA5A5A5A5)) u1 (
        .clk(clk), .rst(rst), .init(init), .busy(busy[1]),
        .data_a(data_a), .we_a(we_a), .addr_a(addr_a), .q_a(qa[1]),
        .data_b(data_b), .we_b(we_b), .addr_b(addr_b), .q_b(qb[1]),
        .coll(coll[1]), .coll_cnt(cnt[1]));
    dpram_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LEVEL(2), .READ_MODE(0), .INIT_VALUE(32'h0)) u2 (
        .clk(clk), .rst(rst), .init(init), .busy(busy[2]),
        .data_a(data_a), .we_a(we_a), .addr_a(addr_a), .q_a(qa[2]),
        .data_b(data_b), .we_b(we_b), .addr_b(addr_b), .q_b(qb[2]),
        .coll(coll[2]), .coll_cnt(cnt[2]));
    dpram_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LEVEL(0), .READ_MODE(0), .INIT_VALUE(32'h5A5A0F0F)) u3 (
        .clk(clk), .rst(rst), .init(init), .busy(busy[3]),
        .data_a(data_a), .we_a(we_a), .addr_a(addr_a), .q_a(qa[3]),
        .data_b(data_b), .we_b(we_b), .addr_b(addr_b), .q_b(qb[3]),
        .coll(coll[3]), .coll_cnt(cnt[3]));

    // Reference model: array contents before/after each edge, sweep progress.
    logic [31:0] mm   [NI][8];
    int          mptr [NI];
    bit          msw  [NI];
    logic [31:0] mqa  [NI];
    logic [31:0] mqb  [NI];
    bit          mcoll[NI];
    int          mcnt [NI];

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int depth;
            int ea;
            int eb;
            logic [31:0] old [8];
            depth = 1 << LV[i];
            if (rst || init) begin
                msw[i]   = 1'b1;
                mptr[i]  = 0;
                mqa[i]   = '0;
                mqb[i]   = '0;
                mcoll[i] = 1'b0;
                if (rst) mcnt[i] = 0;
            end else if (msw[i]) begin
                mm[i][mptr[i]] = IVV[i];
                if (mptr[i] == depth - 1) msw[i] = 1'b0;
                else mptr[i] = mptr[i] + 1;
                mqa[i]   = '0;
                mqb[i]   = '0;
                mcoll[i] = 1'b0;
            end else begin
                ea = int'(addr_a) % depth;
                eb = int'(addr_b) % depth;
                for (int k = 0; k < 8; k++) old[k] = mm[i][k];
                if (we_b) mm[i][eb] = data_b;
                if (we_a) mm[i][ea] = data_a;
                mcoll[i] = we_a && we_b && (ea == eb);
                if (mcoll[i] && mcnt[i] < 65535) mcnt[i] = mcnt[i] + 1;
                mqa[i] = (RMV[i] == 1) ? old[ea] : mm[i][ea];
                mqb[i] = (RMV[i] == 1) ? old[eb] : mm[i][eb];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic int exp_cnt(input int m);
`ifdef DPRAM_SWEEP_COLL_CNT_EN
        return m;
`else
        return 0 * m;
`endif
    endfunction

    task automatic idle_inputs();
        rst = 0; init = 0; we_a = 0; we_b = 0;
        data_a = '0; data_b = '0; addr_a = '0; addr_b = '0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp++; if (busy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_busy inst%0d: got %b expected 1", i, busy[i]); end
            n_cmp++; if (qa[i] !== 32'h0) begin n_fail++; $display("FAIL reset_q_a inst%0d: got %h expected 0", i, qa[i]); end
            n_cmp++; if (qb[i] !== 32'h0) begin n_fail++; $display("FAIL reset_q_b inst%0d: got %h expected 0", i, qb[i]); end
            n_cmp++; if (coll[i] !== 1'b0) begin n_fail++; $display("FAIL reset_coll inst%0d: got %b expected 0", i, coll[i]); end
            n_cmp++; if (cnt[i] !== 16'h0) begin n_fail++; $display("FAIL reset_coll_cnt inst%0d: got %h expected 0", i, cnt[i]); end
        end
        rst = 0;
        n = 0;
        while (busy[0] === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n != 8) begin n_fail++; $display("FAIL sweep_len: got %0d cycles expected 8", n); end
        for (int a = 0; a < 8; a++) begin
            addr_a = 5'(a);
            addr_b = 5'(7 - a);
            tick();
            n_cmp++; if (qa[0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sweep_fill_a addr%0d: got %h expected a5a5a5a5", a, qa[0]); end
            n_cmp++; if (qb[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sweep_fill_b addr%0d: got %h expected a5a5a5a5", 7 - a, qb[1]); end
        end
        n_cmp++; if (qa[3] !== 32'h5A5A0F0F) begin n_fail++; $display("FAIL sweep_fill_single: got %h expected 5a5a0f0f", qa[3]); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we_a = 1; addr_a = 5'd2; data_a = 32'h11;
        tick();
        we_a = 0; addr_b = 5'd2;
        tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp++; if (qb[i] !== 32'h11) begin n_fail++; $display("FAIL bypass_next inst%0d: got %h expected 00000011", i, qb[i]); end
        end
        we_a = 1; addr_a = 5'd3; data_a = 32'h22; addr_b = 5'd3;
        tick();
        n_cmp++; if (qb[0] !== 32'h22) begin n_fail++; $display("FAIL bypass_write_first: got %h expected 00000022", qb[0]); end
        n_cmp++; if (qb[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_read_first: got %h expected a5a5a5a5", qb[1]); end
        n_cmp++; if (qa[0] !== 32'h22) begin n_fail++; $display("FAIL bypass_own_port: got %h expected 00000022", qa[0]); end
        we_a = 0;
        tick();
        n_cmp++; if (qb[1] !== 32'h22) begin n_fail++; $display("FAIL bypass_read_first_after: got %h expected 00000022", qb[1]); end
    endtask

    task automatic test_collision();
        idle_inputs();
        we_a = 1; we_b = 1; addr_a = 5'd5; addr_b = 5'd5; data_a = 32'h1; data_b = 32'h2;
        tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp++; if (coll[i] !== 1'b1) begin n_fail++; $display("FAIL coll_pulse inst%0d: got %b expected 1", i, coll[i]); end
            n_cmp++; if (int'(cnt[i]) != exp_cnt(1)) begin n_fail++; $display("FAIL coll_cnt inst%0d: got %0d expected %0d", i, cnt[i], exp_cnt(1)); end
        end
        we_a = 0; we_b = 0;
        tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp++; if (coll[i] !== 1'b0) begin n_fail++; $display("FAIL coll_width inst%0d: got %b expected 0", i, coll[i]); end
            n_cmp++; if (qa[i] !== 32'h1 || qb[i] !== 32'h1) begin n_fail++; $display("FAIL coll_data inst%0d: got %h/%h expected 00000001", i, qa[i], qb[i]); end
        end
    endtask

    task automatic test_restart();
        int n;
        idle_inputs();
        init = 1;
        tick();
        init = 0;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL restart_mid_busy: got %b expected 1", busy[0]); end
        // Colliding writes with init must be dropped: no pulse, no count.
        init = 1; we_a = 1; we_b = 1; addr_a = 5'd6; addr_b = 5'd6; data_a = 32'hDEAD; data_b = 32'hBEEF;
        tick();
        init = 0; we_a = 0; we_b = 0;
        n_cmp++; if (coll[3] !== 1'b0) begin n_fail++; $display("FAIL restart_drop_coll: got %b expected 0", coll[3]); end
        n_cmp++; if (int'(cnt[3]) != exp_cnt(1)) begin n_fail++; $display("FAIL restart_keep_cnt: got %0d expected %0d", cnt[3], exp_cnt(1)); end
        n = 0;
        while (busy[0] === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n != 8) begin n_fail++; $display("FAIL restart_len: got %0d cycles expected 8", n); end
        addr_a = 5'd6; addr_b = 5'd5;
        tick();
        n_cmp++; if (qa[0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL restart_clear_a: got %h expected a5a5a5a5", qa[0]); end
        n_cmp++; if (qb[0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL restart_clear_b: got %h expected a5a5a5a5", qb[0]); end
        n_cmp++; if (qa[3] !== 32'h5A5A0F0F) begin n_fail++; $display("FAIL restart_single: got %h expected 5a5a0f0f", qa[3]); end
    endtask

    task automatic test_truncation();
        idle_inputs();
        we_a = 1; addr_a = 5'h1D; data_a = 32'h7;
        tick();
        we_a = 0; addr_a = 5'd1; addr_b = 5'd5;
        tick();
        n_cmp++; if (qa[2] !== 32'h7) begin n_fail++; $display("FAIL trunc_l2_a: got %h expected 00000007", qa[2]); end
        n_cmp++; if (qb[2] !== 32'h7) begin n_fail++; $display("FAIL trunc_l2_b: got %h expected 00000007", qb[2]); end
        n_cmp++; if (qb[0] !== 32'h7) begin n_fail++; $display("FAIL trunc_l3_b: got %h expected 00000007", qb[0]); end
        n_cmp++; if (qa[0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL trunc_l3_a: got %h expected a5a5a5a5", qa[0]); end
    endtask

    task automatic test_single_word();
        idle_inputs();
        we_a = 1; addr_a = 5'd9; data_a = 32'hC;
        tick();
        we_a = 0;
        for (int k = 0; k < 4; k++) begin
            addr_a = 5'($urandom_range(0, 31));
            addr_b = 5'($urandom_range(0, 31));
            tick();
            n_cmp++; if (qa[3] !== 32'hC || qb[3] !== 32'hC) begin n_fail++; $display("FAIL single_word: got %h/%h expected 0000000c", qa[3], qb[3]); end
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            we_a   = 1'($urandom_range(0, 1));
            we_b   = 1'($urandom_range(0, 1));
            addr_a = 5'($urandom_range(0, 31));
            addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 5'($urandom_range(0, 31));
            data_a = $urandom;
            data_b = $urandom;
            init   = ($urandom_range(0, 63) == 0);
            tick();
            for (int i = 0; i < NI; i++) begin
                n_cmp++; if (busy[i] !== msw[i]) begin n_fail++; $display("FAIL rand_busy c%0d inst%0d: got %b expected %b", c, i, busy[i], msw[i]); end
                n_cmp++; if (qa[i] !== mqa[i]) begin n_fail++; $display("FAIL rand_q_a c%0d inst%0d: got %h expected %h", c, i, qa[i], mqa[i]); end
                n_cmp++; if (qb[i] !== mqb[i]) begin n_fail++; $display("FAIL rand_q_b c%0d inst%0d: got %h expected %h", c, i, qb[i], mqb[i]); end
                n_cmp++; if (coll[i] !== mcoll[i]) begin n_fail++; $display("FAIL rand_coll c%0d inst%0d: got %b expected %b", c, i, coll[i], mcoll[i]); end
                n_cmp++; if (int'(cnt[i]) != exp_cnt(mcnt[i])) begin n_fail++; $display("FAIL rand_coll_cnt c%0d inst%0d: got %0d expected %0d", c, i, cnt[i], exp_cnt(mcnt[i])); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_bypass();
        test_collision();
        test_restart();
        test_truncation();
        test_single_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/dpram_sweep.md
# dpram_sweep

Parametrised true dual-port RAM for the heap-sort level stores. It extends the level RAM with registered reads, a selectable read-during-write mode, and a defined write-collision policy. A built-in clear sequencer sweeps the whole array to a known value after reset or on request, so a new sort can start without stale heap contents. One instance sits under each heap level; `LEVEL` sets the depth.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 5, address port width.
- `LEVEL`, 1, depth = 2^LEVEL words. Legal range is 0..ADDR_WIDTH.
- `READ_MODE`, 0, read-during-write behaviour: 0 = write-first, 1 = read-first.
- `INIT_VALUE`, 0, DATA_WIDTH-bit word written by the clear sweep.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `init`  in  1  one-cycle request to clear the array.
- `busy`  out  1  high while the clear sweep runs.
- `data_a`  in  DATA_WIDTH  port A write data.
- `we_a`  in  1  port A write enable.
- `addr_a`  in  ADDR_WIDTH  port A address.
- `q_a`  out  DATA_WIDTH  port A registered read data.
- `data_b`, `we_b`, `addr_b`, `q_b`  same as port A, for port B.
- `coll`  out  1  one-cycle pulse on a same-address double write.
- `coll_cnt`  out  16  saturating collision count. Only meaningful when configured in (see Configuration).

## Operation
- **Effective address:** `addr[LEVEL-1:0]`; upper bits are ignored. With LEVEL=0 there is a single word, and every access hits word 0.
- **State machine** has two states, SWEEP and RUN.
  - SWEEP: writes INIT_VALUE to word `ptr`, then increments `ptr`. `busy`=1. User writes are dropped. `q_a`/`q_b` are held at 0.
  - SWEEP exits to RUN in the cycle after `ptr`=DEPTH-1 is written.
  - RUN: normal dual-port access. `busy`=0.
  - `rst` or `init` forces SWEEP with `ptr`=0 from any state, including mid-sweep, which restarts the sweep.
  - `init` has priority over any user write presented in the same cycle; that write is dropped.
- **Writes (RUN):** each port writes independently.
  - Both ports writing the same effective address: port A's data is stored and `coll` pulses for 1 cycle.
  - Different addresses: both writes land.
- **Reads (RUN):** each port reads every cycle; the result appears on `q_x` at the next edge.
  - Write-first (READ_MODE=0): if any port writes the address being read, `q` returns the new stored value. Under collision this is port A's data, for both ports.
  - Read-first (READ_MODE=1): `q` returns the value held before the edge.

## Timing
- Reset values: `busy`=1, `q_a`=`q_b`=0, `coll`=0, `coll_cnt`=0, state SWEEP, `ptr`=0.
- Sweep length: DEPTH cycles. `busy` falls on the edge after the last word is written.
- First user write is accepted in the first cycle with `busy`=0.
- Read latency is 1 cycle: the address presented at edge N produces data valid after edge N+1.
- `coll` is registered: it is high in the cycle after the colliding write edge.
- `coll_cnt` increments on the same edge that `coll` rises and saturates at 0xFFFF.
- `coll_cnt` clears only on `rst`, not on `init`.

## Configuration
- Macro: `DPRAM_SWEEP_COLL_CNT_EN`.
- Defined: the 16-bit saturating collision counter is built and drives `coll_cnt`.
- Undefined: no counter register is built; `coll_cnt` is tied to 0. The `coll` pulse is unaffected either way.

## Structure
- Shared package `dpram_sweep_pkg` holds:
  - `READ_MODE` constants `RM_WRITE_FIRST`=0 and `RM_READ_FIRST`=1.
  - The state enum (`ST_SWEEP`, `ST_RUN`).
  - The collision counter width (16).
- One sub-module, `dpram_sweep_seq`, contains the SWEEP/RUN FSM and the `ptr` counter. It outputs `busy`, the sweep write enable and the sweep address.
- The top level muxes the sweep write onto port A and keeps the storage array and the read registers.

## Test plan
- **Reset sweep.** LEVEL=3, INIT_VALUE=0xA5A5A5A5; pulse `rst` -> `busy` high for exactly 8 cycles; afterwards reading all 8 addresses returns 0xA5A5A5A5.
- **Cross-port bypass.** Write A addr 2 = 0x11; next cycle read B addr 2 -> `q_b`=0x11 one cycle later. In the same cycle, write A addr 3 = 0x22 with B reading addr 3 -> `q_b`=0x22 when READ_MODE=0, old value when READ_MODE=1.
- **Collision.** A and B both write addr 5, with 0x1 and 0x2 -> stored 0x1; `coll` high for exactly 1 cycle; `coll_cnt`=1 with the macro defined, 0 without.
- **Restart and dropped write.** `init` during sweep at `ptr`=4 -> sweep restarts at 0 and `busy` stays high for 8 more cycles. A write presented in the same cycle as `init` is lost.
- **Address truncation.** LEVEL=2, write addr 0x1D = 0x7 -> reading addr 1 returns 0x7.
- **Single word.** LEVEL=0, write A addr 9 = 0xC -> `q_a`=`q_b`=0xC for any address.
